alu_issue: RTL and testbench

Single-issue decode and operand-fetch stage that sits directly upstream of `alu`. It accepts 8-bit instructions over a valid/ready handshake and reads operands from an internal 4×8 register file. It drives the ALU's `a`, `b`, `control` and `f` inputs from registered operands, captures the ALU result `c`, and writes it back to the register file. It also handles a two-byte load-immediate and flags illegal opcodes.

---
 rtl/alu_issue.sv | 151 +++++++++++++++
 tb/tb_alu_issue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Decode/operand-fetch stage feeding the external alu: 4x8 register file, LDI, illegal-op flag.
// Define ALU_ISSUE_ZERO_REG_EN to hardwire r0 to 0x00.
module alu_issue #(
  parameter int unsigned NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  output logic       alu_f,
  input  logic [7:0] alu_c,
  output logic       wb_valid,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       illegal,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StImm, StExec, StWb} state_e;

  localparam logic [2:0] OpLogic = 3'b000;
  localparam logic [2:0] OpArith = 3'b011;
  localparam logic [2:0] OpShift = 3'b100;
  localparam logic [2:0] OpLdi   = 3'b111;

  state_e                  state_q, state_d;
  logic [NREGS-1:0][7:0]   regs_q, regs_d;
  logic [7:0]              alu_a_q, alu_a_d;
  logic [7:0]              alu_b_q, alu_b_d;
  logic [2:0]              alu_ctrl_q, alu_ctrl_d;
  logic                    alu_f_q, alu_f_d;
  logic [1:0]              rd_q, rd_d;
  logic [7:0]              res_q, res_d;
  logic                    illegal_q, illegal_d;

  logic [2:0] op;
  logic       f_bit;
  logic [1:0] rd;
  logic [1:0] rs2;
  logic       accept;
  logic       wr_en;

  assign op    = instr[7:5];
  assign f_bit = instr[4];
  assign rd    = instr[3:2];
  assign rs2   = instr[1:0];

  // Ready is a function of state only; reset forces it low while asserted.
  assign instr_ready = ~rst & ((state_q == StIdle) | (state_q == StImm));
  assign accept      = instr_valid & instr_ready;

`ifdef ALU_ISSUE_ZERO_REG_EN
  // r0 never leaves its reset value, so reads of r0 return 0x00 without a read-side mux.
  assign wr_en = (rd_q != 2'd0);
`else
  assign wr_en = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_f_d    = alu_f_q;
    rd_d       = rd_q;
    res_d      = res_q;
    illegal_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpLogic, OpArith, OpShift: begin
              alu_a_d    = regs_q[rd];
              alu_b_d    = regs_q[rs2];
              alu_ctrl_d = op;
              alu_f_d    = f_bit;
              rd_d       = rd;
              state_d    = StExec;
            end
            OpLdi: begin
              rd_d    = rd;
              state_d = StImm;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      StImm: begin
        if (accept) begin
          res_d   = instr;
          state_d = StWb;
        end
      end
      StExec: begin
        res_d   = alu_c;
        state_d = StWb;
      end
      StWb: begin
        if (wr_en) begin
          regs_d[rd_q] = res_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      regs_q     <= '0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_ctrl_q <= 3'b000;
      alu_f_q    <= 1'b0;
      rd_q       <= 2'd0;
      res_q      <= 8'h00;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_f_q    <= alu_f_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;
  assign alu_f    = alu_f_q;

  // The write lands at the end of the WB cycle, so a debug read during WB still sees the old value.
  assign wb_valid = ~rst & (state_q == StWb);
  assign wb_addr  = rd_q;
  assign wb_data  = res_q;
  assign illegal  = illegal_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural alu model on alu_c.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_ctrl;
  logic       alu_f;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       illegal;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] wb_q[$];
  int exp_illegal = 0;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_f      (alu_f),
    .alu_c      (alu_c),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural alu.
  always_comb begin
    alu_c = 8'h00;
    case (alu_ctrl)
      3'b000: alu_c = alu_f ? ~(alu_a & alu_b) : ~(alu_a | alu_b);
      3'b011: alu_c = alu_f ? alu_a + alu_b : alu_a - alu_b;
      3'b100: alu_c = alu_f ? alu_a >> alu_b : alu_a << alu_b;
      default: alu_c = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every writeback and illegal pulse.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        check("unexpected_wb", {22'd0, wb_addr, wb_data}, 32'hFFFF_FFFF);
      end else begin
        check("wb", {22'd0, wb_addr, wb_data}, {22'd0, wb_q.pop_front()});
      end
    end
    if (illegal) begin
      check("illegal_expected", (exp_illegal > 0) ? 1 : 0, 1);
      if (exp_illegal > 0) exp_illegal--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int cyc;
    cyc = 0;
    instr       = b;
    instr_valid = 1'b1;
    while (!instr_ready && cyc < 50) begin
      step();
      cyc++;
    end
    if (cyc >= 50) check("accept_timeout", 0, 1);
    step();
    instr_valid = 1'b0;
  endtask

  task automatic dbg(input logic [1:0] a, input logic [7:0] exp, input string name);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic ldi(input logic [7:0] op_byte, input logic [1:0] r, input logic [7:0] imm);
    send(op_byte);
    wb_q.push_back({r, imm});
    send(imm);
    step();
  endtask

  // ALU op with valid held high through EXEC/WB; checks latched operands and ready spacing.
  task automatic alu_op(input logic [7:0] b, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [2:0] ec, input logic ef, input logic [7:0] res);
    wb_q.push_back({b[3:2], res});
    send(b);
    instr_valid = 1'b1;
    check("ready_exec", instr_ready, 0);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_ctrl_f", {alu_ctrl, alu_f}, {ec, ef});
    step();
    check("ready_wb", instr_ready, 0);
    step();
    instr_valid = 1'b0;
    check("ready_after", instr_ready, 1);
  endtask

  initial begin
    rst = 1'b1; instr = 8'h00; instr_valid = 1'b0; dbg_addr = 2'd0;
    step(); step();
    check("rst_ready", instr_ready, 0);
    check("rst_wb", {wb_valid, wb_addr, wb_data, illegal}, 0);
    check("rst_alu", {alu_a, alu_b, alu_ctrl, alu_f}, 0);
    rst = 1'b0;
    #1;
    check("ready_post_rst", instr_ready, 1);
    for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "reg_reset");

    // LDI r1=0x0F, r2=0x05; debug read during WB shows old value.
    ldi(8'hE4, 2'd1, 8'h0F);
    send(8'hE8);
    wb_q.push_back({2'd2, 8'h05});
    send(8'h05);
    dbg(2'd2, 8'h00, "dbg_old_in_wb");
    step();
    dbg(2'd2, 8'h05, "dbg_r2");
    dbg(2'd1, 8'h0F, "dbg_r1");

    alu_op(8'h76, 8'h0F, 8'h05, 3'b011, 1'b1, 8'h14);   // ADD
    dbg(2'd1, 8'h14, "add_r1");
    ldi(8'hE4, 2'd1, 8'h0F);
    alu_op(8'h16, 8'h0F, 8'h05, 3'b000, 1'b1, 8'hFA);   // NAND
    ldi(8'hE4, 2'd1, 8'h0F);
    alu_op(8'h66, 8'h0F, 8'h05, 3'b011, 1'b0, 8'h0A);   // SUB
    alu_op(8'h06, 8'h0A, 8'h05, 3'b000, 1'b0, 8'hF0);   // NOR
    alu_op(8'h96, 8'hF0, 8'h05, 3'b100, 1'b1, 8'h07);   // SRL
    alu_op(8'h86, 8'h07, 8'h05, 3'b100, 1'b0, 8'hE0);   // SLL
    ldi(8'hEC, 2'd3, 8'hFF);
    alu_op(8'h7F, 8'hFF, 8'hFF, 3'b011, 1'b1, 8'hFE);   // ADD wraps
    ldi(8'hF7, 2'd1, 8'h3C);                            // LDI ignores [4] and [1:0]
    dbg(2'd1, 8'h3C, "ldi_ignored_bits");

    // Illegal ops: pulse only, no writeback, alu regs and register file untouched.
    exp_illegal = 2;
    send(8'h20);
    check("ready_illegal", instr_ready, 1);
    send(8'hA0);
    step(); step();
    check("illegal_all_seen", exp_illegal, 0);
    check("alu_hold", {alu_a, alu_ctrl}, {8'hFF, 3'b011});
    dbg(2'd1, 8'h3C, "illegal_regs");

    // LDI to r0.
    ldi(8'hE0, 2'd0, 8'h55);
`ifdef ALU_ISSUE_ZERO_REG_EN
    dbg(2'd0, 8'h00, "zero_reg");
`else
    dbg(2'd0, 8'h55, "r0_plain");
`endif

    // Reset while in IMM with a valid byte presented.
    send(8'hE4);
    rst = 1'b1; instr = 8'hAA; instr_valid = 1'b1;
    #1;
    check("ready_in_rst", instr_ready, 0);
    step();
    rst = 1'b0; instr_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "reg_after_midrst");
    check("ready_after_midrst", instr_ready, 1);
    ldi(8'hE8, 2'd2, 8'h33);
    dbg(2'd2, 8'h33, "ldi_after_rst");

    step(); step();
    check("scoreboard_empty", wb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

endmodule
